fft_frame_ctrl: RTL
===================

// Module: fft_frame_ctrl
// PURPOSE
//  Frame sequencer between the XADC stream, the streaming FFT core and the output buffer.
//  - Gates ADC samples into the FFT in frames of N_POINTS, with optional decimation.
//  - Zero-flushes the FFT pipeline and gates result writes into the output buffer.
//  - Waits for the USB side to drain the buffer, then re-arms.
//  - Replaces the free-running enable = ~buff_full & enable_sw glue.
// PARAMETERS
//  N_POINTS    1024  FFT length, power of two; one frame = N_POINTS FFT inputs
//  LOG2N       10    log2(N_POINTS)
//  FFT_LAT     1024  FFT core enable-cycles from first input to first valid output (1..N_POINTS)
//  DECIM       1     forward 1 of every DECIM accepted ADC samples (1..256)
//  FRAME_CW    16    frame counter width
// PORTS
//  CLK          in   1         system clock (50 MHz domain)
//  rstn         in   1         asynchronous active-low reset
//  enable_sw    in   1         run switch, asynchronous; synchronised internally
//  s_tvalid     in   1         XADC m_axis_tvalid
//  s_tready     out  1         to XADC m_axis_tready
//  buff_full    in   1         output buffer full (CLK domain)
//  buff_empty   in   1         output buffer empty (CLK domain)
//  fft_enable   out  1         FFT core enable (one input per high cycle)
//  fft_zero     out  1         1: FFT input mux selects 0 instead of ADC data
//  out_wr       out  1         output buffer write enable (FFT output valid)
//  frame_start  out  1         1-cycle pulse on first FFT input of a frame
//  frame_done   out  1         1-cycle pulse when a frame is fully drained
//  frame_cnt    out  FRAME_CW  completed frames, wraps modulo 2^FRAME_CW
//  overrun      out  1         sticky: ADC sample offered while stalled in ACQ
//  clr_ovr      in   1         synchronous clear of overrun
//  busy         out  1         state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; sync flops 0.
//  en_s = enable_sw after a 2-FF synchroniser (2-cycle latency).
//  feed_cnt counts FFT inputs in the frame; width LOG2N+1; cleared on ARM->ACQ.
//  States:
//   IDLE : s_tready=0. en_s=1 -> ARM.
//   ARM  : wait until buff_empty=1 and buff_full=0 -> ACQ. en_s=0 -> IDLE.
//   ACQ  : s_tready=~buff_full.
//          - accept = s_tvalid & s_tready; decim_cnt advances on each accept.
//          - fft_enable=1, fft_zero=0 on the accept where decim_cnt==0 (combinational, same cycle).
//          - On the N_POINTS-th input -> FLUSH (-> DRAIN if FFT_LAT==0).
//   FLUSH: s_tready=0; fft_zero=1; fft_enable=~buff_full; FFT_LAT zero inputs, then -> DRAIN.
//   DRAIN: no FFT activity; wait buff_empty=1 -> frame_done pulse, frame_cnt+1.
//          en_s=1 -> ARM, else -> IDLE.
//  Output gating:
//   - out_wr = fft_enable & (feed_cnt >= FFT_LAT), giving exactly N_POINTS writes per frame.
//   - frame_start = fft_enable & (feed_cnt==0).
//  Boundaries:
//   - buff_full in ACQ/FLUSH: stall; no enable or write; resume on the next cycle it clears.
//   - overrun sets when state==ACQ & s_tvalid & buff_full; clr_ovr wins over a same-cycle set.
//   - en_s drop mid-frame: the frame completes through DRAIN, then IDLE (no partial frames).
//   - DECIM==1: every accept feeds the FFT. decim_cnt resets on entry to ACQ.
//   - frame_cnt wraps from all-ones to 0 without flag.
//   - rstn low at any time: immediate return to reset state; the FFT core is reset separately.
// STRUCTURE
//  - Shared header fft_ctrl_defs.vh: state encodings (IDLE, ARM, ACQ, FLUSH, DRAIN as
//    3-bit localparams) and N_POINTS/LOG2N defaults, shared with FFT_top and Output_buffer.
//  - One sub-module: sync_2ff (generic 2-flop bit synchroniser) for enable_sw.
//  - The rest is a single FSM plus feed_cnt, decim_cnt, frame_cnt and the overrun flop.
// TESTING (N_POINTS=8, LOG2N=3, FFT_LAT=3, DECIM=1 unless noted)
//  1. s_tvalid=1 constant, buff_empty=1, enable_sw 0->1:
//     - frame_start 3 cycles after enable_sw rises (2-FF sync + ARM);
//     - then 8 fft_enable (fft_zero=0) and 3 with fft_zero=1;
//     - out_wr on input indices 3..10, total 8;
//     - frame_done once buff_empty is high again; frame_cnt=1.
//  2. buff_full held high for 4 cycles after the 5th input:
//     - no fft_enable/out_wr during the stall; overrun=1;
//     - counts still total 8 inputs + 3 flush; clr_ovr -> overrun=0.
//  3. DECIM=4, s_tvalid=1: fft_enable every 4th accept; 32 accepts per frame before FLUSH.
//  4. enable_sw 1->0 during ACQ input 4: frame completes with 8 out_wr and frame_done, then
//     IDLE with busy=0; a second frame starts only after enable_sw goes high again.
//  5. rstn pulsed low in FLUSH: all outputs 0 asynchronously; after release and enable_sw=1,
//     a fresh frame runs with feed_cnt from 0.
//  6. FRAME_CW=2, run 5 frames: frame_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared definitions for the FFT frame sequencer: state encoding and
// default frame geometry used by the controller and its neighbours.
package fft_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_ACQ   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int N_POINTS_DEF = 1024;
  localparam int LOG2N_DEF    = 10;
  localparam int FFT_LAT_DEF  = 1024;
  localparam int DECIM_DEF    = 1;
  localparam int FRAME_CW_DEF = 16;

  // Decimation counter covers DECIM up to 256 (counts 0..255).
  localparam int DECIM_CW     = 8;

endpackage

// File: rtl/fft_frame_ctrl_sync_2ff.sv
// Two-flop bit synchroniser for a slow asynchronous level (the run switch).
module fft_frame_ctrl_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture flop followed by the resolving flop; both clear on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer between the XADC stream, the streaming FFT core and the
// output buffer. Feeds N_POINTS (optionally decimated) samples per frame,
// zero-flushes the FFT pipeline, gates result writes and re-arms once the
// buffer has been drained.
//
//  state | meaning
//  IDLE  | run switch off, nothing accepted
//  ARM   | waiting for an empty, non-full output buffer
//  ACQ   | forwarding ADC samples into the FFT
//  FLUSH | pushing FFT_LAT zero inputs to flush the pipeline
//  DRAIN | waiting for the USB side to empty the buffer
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int LOG2N    = LOG2N_DEF,
  parameter int FFT_LAT  = FFT_LAT_DEF,
  parameter int DECIM    = DECIM_DEF,
  parameter int FRAME_CW = FRAME_CW_DEF
) (
  input  logic                CLK,
  input  logic                rstn,
  input  logic                enable_sw,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                buff_full,
  input  logic                buff_empty,
  output logic                fft_enable,
  output logic                fft_zero,
  output logic                out_wr,
  output logic                frame_start,
  output logic                frame_done,
  output logic [FRAME_CW-1:0] frame_cnt,
  output logic                overrun,
  input  logic                clr_ovr,
  output logic                busy
);

  // feed_cnt spans data plus flush inputs, at most 2*N_POINTS-1.
  localparam int FCW = LOG2N + 1;
  localparam logic [FCW-1:0]      C_LAT        = FCW'(FFT_LAT);
  localparam logic [FCW-1:0]      C_ACQ_LAST   = FCW'(N_POINTS - 1);
  localparam logic [FCW-1:0]      C_FLUSH_LAST = FCW'(N_POINTS + FFT_LAT - 1);
  localparam logic [DECIM_CW-1:0] C_DEC_LAST   = DECIM_CW'(DECIM - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_en_s;
  logic [FCW-1:0]      r_feed_cnt;
  logic [DECIM_CW-1:0] r_decim_cnt;
  logic [FRAME_CW-1:0] r_frame_cnt;
  logic                r_overrun;
  logic                w_accept;
  logic                w_fft_en;
  logic                w_fft_zero;
  logic                w_tready;
  logic                w_done;
  logic                w_ovr_set;
  logic                w_start_acq;

  fft_frame_ctrl_sync_2ff u_sync_en (
    .i_clk   (CLK),
    .i_rst_n (rstn),
    .i_d     (enable_sw),
    .o_q     (w_en_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the per-state stream/FFT handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_tready    = 1'b0;
    w_accept    = 1'b0;
    w_fft_en    = 1'b0;
    w_fft_zero  = 1'b0;
    w_done      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en_s) begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!w_en_s) begin
          w_state_nxt = ST_IDLE;
        end else if (buff_empty && !buff_full) begin
          w_state_nxt = ST_ACQ;
        end
      end
      ST_ACQ: begin
        w_tready  = ~buff_full;
        w_accept  = s_tvalid & ~buff_full;
        w_fft_en  = w_accept & (r_decim_cnt == '0);
        w_ovr_set = s_tvalid & buff_full;
        if (w_fft_en && (r_feed_cnt == C_ACQ_LAST)) begin
          w_state_nxt = (FFT_LAT == 0) ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_fft_zero = 1'b1;
        w_fft_en   = ~buff_full;
        if (w_fft_en && (r_feed_cnt == C_FLUSH_LAST)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (buff_empty) begin
          w_done      = 1'b1;
          w_state_nxt = w_en_s ? ST_ARM : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_start_acq = (r_state == ST_ARM) && (w_state_nxt == ST_ACQ);

  // Count FFT inputs (data and zeros) within the current frame.
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      r_feed_cnt <= '0;
    end else if (w_start_acq) begin
      r_feed_cnt <= '0;
    end else if (w_fft_en) begin
      r_feed_cnt <= r_feed_cnt + 1'b1;
    end
  end

  // Decimation phase: only the first accept of each DECIM group is forwarded.
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      r_decim_cnt <= '0;
    end else if (w_start_acq) begin
      r_decim_cnt <= '0;
    end else if (w_accept) begin
      r_decim_cnt <= (r_decim_cnt == C_DEC_LAST) ? '0 : r_decim_cnt + 1'b1;
    end
  end

  // Completed-frame counter, wraps silently.
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= '0;
    end else if (w_done) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Sticky overrun; a same-cycle clear takes priority over a new set.
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      r_overrun <= 1'b0;
    end else if (clr_ovr) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end
  end

  // The first FFT_LAT outputs are pipeline fill, so writes start at that index.
  assign s_tready    = w_tready;
  assign fft_enable  = w_fft_en;
  assign fft_zero    = w_fft_zero;
  assign out_wr      = w_fft_en & (r_feed_cnt >= C_LAT);
  assign frame_start = w_fft_en & (r_feed_cnt == '0);
  assign frame_done  = w_done;
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;
  assign busy        = (r_state != ST_IDLE);

endmodule
